// File: rtl/alu_logic.sv
// Board ALU wrapper: buttons capture A, B and opcode from shared switches; optional ALU_STATUS_EN adds zero/carry/overflow flags.
// Latency: result is combinational from the registers, valid right after the edge that loads the last register.
// Backpressure: none; buttons are plain level enables and a held button reloads on every edge.
module alu_logic #(
  parameter int OPERAND_SIZE = 8,
  parameter int OP_CODE_SIZE = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [OPERAND_SIZE-1:0] i_switches,
  input  logic                    i_btn_A,
  input  logic                    i_btn_B,
  input  logic                    i_btn_OP,
`ifdef ALU_STATUS_EN
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_overflow,
`endif
  output logic [OPERAND_SIZE-1:0] o_resultado
);

  localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(6'b100000);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(6'b100010);
  localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(6'b100100);
  localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(6'b100101);
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(6'b100110);
  localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(6'b100111);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(6'b000011);
  localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(6'b000010);

  localparam int MSB = OPERAND_SIZE - 1;

  logic [OPERAND_SIZE-1:0] regA;
  logic [OPERAND_SIZE-1:0] regB;
  logic [OP_CODE_SIZE-1:0] regOp;
  logic [OPERAND_SIZE-1:0] addRes;
  logic [OPERAND_SIZE-1:0] subRes;
  logic [OPERAND_SIZE-1:0] aluRes;

  // Reset wins over every button; each button is an independent load enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      regA  <= '0;
      regB  <= '0;
      regOp <= '0;
    end else begin
      if (i_btn_A)  regA  <= i_switches;
      if (i_btn_B)  regB  <= i_switches;
      if (i_btn_OP) regOp <= i_switches[OP_CODE_SIZE-1:0];
    end
  end

`ifdef ALU_STATUS_EN
  logic addCarry;
  logic subBorrow;
  logic loaded;

  assign {addCarry, addRes}  = {1'b0, regA} + {1'b0, regB};
  assign {subBorrow, subRes} = {1'b0, regA} - {1'b0, regB};

  // Keeps o_zero low from reset until something has actually been loaded.
  always_ff @(posedge i_clk) begin
    if (i_reset) loaded <= 1'b0;
    else if (i_btn_A || i_btn_B || i_btn_OP) loaded <= 1'b1;
  end

  always_comb begin
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    if (regOp == OP_ADD) begin
      o_carry    = addCarry;
      o_overflow = (regA[MSB] == regB[MSB]) && (addRes[MSB] != regA[MSB]);
    end else if (regOp == OP_SUB) begin
      o_carry    = subBorrow;
      o_overflow = (regA[MSB] != regB[MSB]) && (subRes[MSB] != regA[MSB]);
    end
  end

  assign o_zero = loaded && (aluRes == '0);
`else
  assign addRes = regA + regB;
  assign subRes = regA - regB;
`endif

  // Shift amount is the full value of B, so B >= width saturates naturally.
  always_comb begin
    aluRes = '0;
    case (regOp)
      OP_ADD:  aluRes = addRes;
      OP_SUB:  aluRes = subRes;
      OP_AND:  aluRes = regA & regB;
      OP_OR:   aluRes = regA | regB;
      OP_XOR:  aluRes = regA ^ regB;
      OP_NOR:  aluRes = ~(regA | regB);
      OP_SRA:  aluRes = $signed(regA) >>> regB;
      OP_SRL:  aluRes = regA >> regB;
      default: aluRes = '0;
    endcase
  end

  assign o_resultado = aluRes;

endmodule

// File: tb/tb_alu_logic.sv
// Directed bench for alu_logic: button loads, every opcode, shift saturation, reset priority.
module tb_alu_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btnA, btnB, btnOp;
  logic [7:0] res;

  int checks = 0;
  int errors = 0;

  alu_logic #(.OPERAND_SIZE(8), .OP_CODE_SIZE(6)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_switches  (sw),
    .i_btn_A     (btnA),
    .i_btn_B     (btnB),
    .i_btn_OP    (btnOp),
    .o_resultado (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] expected);
    checks++;
    assert (res === expected)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%h expected 0x%h", tag, res, expected);
      end
  endtask

  // Drive one edge with the given buttons, then release them; returns on the following negedge.
  task automatic press(input logic [7:0] val, input logic a, input logic b, input logic op);
    @(negedge clk);
    sw = val; btnA = a; btnB = b; btnOp = op;
    @(negedge clk);
    btnA = 1'b0; btnB = 1'b0; btnOp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 8'hA5; btnA = 1'b0; btnB = 1'b0; btnOp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", 8'h00);
    @(negedge clk); sw = 8'hFF;
    @(negedge clk); sw = 8'h3C;
    check("idle_sw_toggle", 8'h00);

    // NOR sequence; result stays 0 until the opcode is loaded.
    press(8'h08, 1'b0, 1'b1, 1'b0);
    press(8'h04, 1'b1, 1'b0, 1'b0);
    check("ab_loaded_op0", 8'h00);
    press(8'h27, 1'b0, 1'b0, 1'b1);
    check("nor", 8'hF3);
    @(negedge clk); sw = 8'h99;
    @(negedge clk);
    check("hold_no_btn", 8'hF3);

    // Arithmetic
    press(8'hFF, 1'b1, 1'b0, 1'b0);
    press(8'h01, 1'b0, 1'b1, 1'b0);
    press(8'h20, 1'b0, 1'b0, 1'b1);
    check("add_wrap", 8'h00);
    press(8'h7F, 1'b1, 1'b0, 1'b0);
    check("add_7f_1", 8'h80);
    press(8'h05, 1'b1, 1'b0, 1'b0);
    press(8'h07, 1'b0, 1'b1, 1'b0);
    press(8'h22, 1'b0, 1'b0, 1'b1);
    check("sub_neg", 8'hFE);
    press(8'h80, 1'b1, 1'b0, 1'b0);
    press(8'h01, 1'b0, 1'b1, 1'b0);
    check("sub_ovf", 8'h7F);

    // Logic ops
    press(8'hCA, 1'b1, 1'b0, 1'b0);
    press(8'h5C, 1'b0, 1'b1, 1'b0);
    press(8'h24, 1'b0, 1'b0, 1'b1);
    check("and", 8'h48);
    press(8'h25, 1'b0, 1'b0, 1'b1);
    check("or", 8'hDE);
    press(8'h26, 1'b0, 1'b0, 1'b1);
    check("xor", 8'h96);

    // Shifts, including amounts at and beyond the operand width
    press(8'h80, 1'b1, 1'b0, 1'b0);
    press(8'h02, 1'b0, 1'b1, 1'b0);
    press(8'h03, 1'b0, 1'b0, 1'b1);
    check("sra_2", 8'hE0);
    press(8'h02, 1'b0, 1'b0, 1'b1);
    check("srl_2", 8'h20);
    press(8'h09, 1'b0, 1'b1, 1'b0);
    check("srl_9", 8'h00);
    press(8'h03, 1'b0, 1'b0, 1'b1);
    check("sra_9", 8'hFF);
    press(8'h08, 1'b0, 1'b1, 1'b0);
    check("sra_8", 8'hFF);
    press(8'h40, 1'b1, 1'b0, 1'b0);
    check("sra_pos_8", 8'h00);
    press(8'h01, 1'b0, 1'b1, 1'b0);
    check("sra_pos_1", 8'h20);
    press(8'h02, 1'b0, 1'b0, 1'b1);
    press(8'h81, 1'b1, 1'b0, 1'b0);
    check("srl_1", 8'h40);

    // Undefined opcode, and opcode upper switch bits ignored
    press(8'h3F, 1'b0, 1'b0, 1'b1);
    check("undef_3f", 8'h00);
    press(8'hE0, 1'b0, 1'b0, 1'b1);
    check("op_upper_bits_ignored", 8'h82);

    // Two buttons on one edge load the same value
    press(8'h11, 1'b1, 1'b1, 1'b0);
    check("ab_together", 8'h22);

    // Held button reloads each edge
    press(8'h01, 1'b0, 1'b1, 1'b0);
    @(negedge clk); sw = 8'h10; btnA = 1'b1;
    @(negedge clk);
    check("held_a_1", 8'h11);
    sw = 8'h20;
    @(negedge clk);
    check("held_a_2", 8'h21);

    // Reset has priority over buttons held high
    sw = 8'h20; btnA = 1'b1; btnB = 1'b1; btnOp = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("reset_over_btns", 8'h00);
    rst = 1'b0; btnA = 1'b0; btnB = 1'b0; btnOp = 1'b0;
    @(negedge clk);
    check("after_reset_idle", 8'h00);
    press(8'h20, 1'b0, 1'b0, 1'b1);
    check("regs_cleared", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
